// File: rtl/vga_sync_decoder.sv
// Recovers pixel position from an hsync/vsync stream, checks it against the
// expected VGA timing, and reports lock state, sync errors and an error count.
module vga_sync_decoder #(
  parameter int          LOCK_FRAMES  = 2,
  parameter int          H_COUNT_TOT  = 1344,
  parameter int          H_SYNC_START = 1048,
  parameter int          H_SYNC_END   = 1184,
  parameter int          V_COUNT_TOT  = 806,
  parameter int          V_SYNC_START = 771,
  parameter int          V_SYNC_END   = 777,
  parameter logic [15:0] ERR_MAX      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        locked,
  output logic        frame_start,
  output logic        sync_err,
  output logic [15:0] err_cnt
);

  localparam logic [10:0] H_LAST  = 11'(H_COUNT_TOT - 1);
  localparam logic [10:0] H_START = 11'(H_SYNC_START);
  localparam logic [10:0] H_END   = 11'(H_SYNC_END);
  localparam logic [10:0] V_LAST  = 11'(V_COUNT_TOT - 1);
  localparam logic [10:0] V_START = 11'(V_SYNC_START);
  localparam logic [10:0] V_END   = 11'(V_SYNC_END);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, H_ACQ, V_ACQ, LOCKED} state_t;

  state_t      state;
  logic [10:0] h, v;
  logic        prev_hs, prev_vs;
  logic [3:0]  good_cnt;

  logic        hs_rise, vs_rise;
  logic [10:0] h_cur, v_cur, h_nxt, v_nxt;
  logic        exp_hs, exp_vs, hs_bad, vs_bad, err, pos_zero;
  logic [3:0]  good_inc;

  // h_cur/v_cur are the positions assigned to the current sample, including
  // any realignment that happens on this very sample.
  always_comb begin
    hs_rise  = hsync_in & ~prev_hs;
    vs_rise  = vsync_in & ~prev_vs;
    h_cur    = (state == SEARCH && hs_rise) ? H_START : h;
    v_cur    = (state == H_ACQ && vs_rise) ? V_START : v;
    exp_hs   = (h_cur >= H_START) && (h_cur < H_END);
    exp_vs   = (v_cur >= V_START) && (v_cur < V_END);
    hs_bad   = hsync_in != exp_hs;
    vs_bad   = vsync_in != exp_vs;
    pos_zero = (h_cur == 11'd0) && (v_cur == 11'd0);
    good_inc = good_cnt + 4'd1;
    case (state)
      SEARCH:  err = 1'b0;
      H_ACQ:   err = hs_bad;
      default: err = hs_bad | vs_bad;
    endcase
    h_nxt = h_cur;
    v_nxt = v_cur;
    if (h_cur == H_LAST) begin
      h_nxt = 11'd0;
      v_nxt = (v_cur == V_LAST) ? 11'd0 : v_cur + 11'd1;
    end else begin
      h_nxt = h_cur + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SEARCH;
      h           <= '0;
      v           <= '0;
      prev_hs     <= 1'b1;
      prev_vs     <= 1'b1;
      good_cnt    <= '0;
      hcount_out  <= '0;
      vcount_out  <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      err_cnt     <= '0;
    end else begin
      prev_hs     <= hsync_in;
      prev_vs     <= vsync_in;
      h           <= h_nxt;
      v           <= v_nxt;
      hcount_out  <= h_cur;
      vcount_out  <= v_cur;
      sync_err    <= err;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      if (err && err_cnt < ERR_MAX) err_cnt <= err_cnt + 16'd1;
      if (err) begin
        state    <= SEARCH;
        good_cnt <= '0;
      end else begin
        case (state)
          SEARCH: begin
            good_cnt <= '0;
            if (hs_rise) state <= H_ACQ;
          end
          H_ACQ: if (vs_rise) state <= V_ACQ;
          V_ACQ: begin
            if (vs_rise) begin
              good_cnt <= good_inc;
              if (good_inc == LOCK_N) begin
                state       <= LOCKED;
                locked      <= 1'b1;
                frame_start <= pos_zero;
              end
            end
          end
          default: begin
            locked      <= 1'b1;
            frame_start <= pos_zero;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomised stream bench for vga_sync_decoder on a reduced raster, with a
// position-based reference model feeding a scoreboard queue.
module tb_vga_sync_decoder;
  localparam int HT = 32, HSS = 20, HSE = 24;
  localparam int VT = 12, VSS = 8, VSE = 10;
  localparam int LF = 2;
  localparam int FRAME = HT * VT;
  localparam logic [15:0] EMAX = 16'd256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [10:0] hcount_out, vcount_out;
  logic        locked, frame_start, sync_err;
  logic [15:0] err_cnt;

  vga_sync_decoder #(
    .LOCK_FRAMES(LF), .H_COUNT_TOT(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .V_COUNT_TOT(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .ERR_MAX(EMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .locked(locked),
    .frame_start(frame_start), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h; int v; bit lk; bit fs; bit er; int cnt;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: one linear position within the frame, plus a mode number.
  localparam int M_SEARCH = 0, M_HACQ = 1, M_VACQ = 2, M_LOCK = 3;
  int m_mode = M_SEARCH, m_good = 0, m_pos = 0, m_cnt = 0;
  bit m_phs = 1'b1, m_pvs = 1'b1;

  task automatic model_step(input bit r, input bit hs, input bit vs);
    exp_t e;
    int hh, vv;
    bit hr, vr, ehs, evs, bad;
    if (!r) begin
      m_mode = M_SEARCH; m_good = 0; m_pos = 0; m_cnt = 0;
      m_phs = 1'b1; m_pvs = 1'b1;
      e = '{0, 0, 1'b0, 1'b0, 1'b0, 0};
    end else begin
      hr = hs && !m_phs;
      vr = vs && !m_pvs;
      hh = m_pos % HT;
      vv = m_pos / HT;
      if (m_mode == M_SEARCH && hr) hh = HSS;
      if (m_mode == M_HACQ && vr) vv = VSS;
      ehs = (hh >= HSS && hh < HSE);
      evs = (vv >= VSS && vv < VSE);
      bad = 1'b0;
      if (m_mode == M_HACQ) bad = (hs != ehs);
      if (m_mode >= M_VACQ) bad = (hs != ehs) || (vs != evs);
      if (bad) begin
        m_mode = M_SEARCH; m_good = 0;
        if (m_cnt < int'(EMAX)) m_cnt++;
      end else if (m_mode == M_SEARCH) begin
        m_good = 0;
        if (hr) m_mode = M_HACQ;
      end else if (m_mode == M_HACQ) begin
        if (vr) m_mode = M_VACQ;
      end else if (m_mode == M_VACQ && vr) begin
        m_good++;
        if (m_good == LF) m_mode = M_LOCK;
      end
      e.h = hh; e.v = vv;
      e.lk = (m_mode == M_LOCK);
      e.fs = e.lk && hh == 0 && vv == 0;
      e.er = bad;
      e.cnt = m_cnt;
      m_pos = (vv * HT + hh + 1) % FRAME;
      m_phs = hs; m_pvs = vs;
    end
    q.push_back(e);
  endtask

  task automatic cmp(input string nm, input int act, input int req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, req);
    end
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      vectors++;
      cmp("hcount", int'(hcount_out), mon_e.h);
      cmp("vcount", int'(vcount_out), mon_e.v);
      cmp("locked", int'(locked), int'(mon_e.lk));
      cmp("frame_start", int'(frame_start), int'(mon_e.fs));
      cmp("sync_err", int'(sync_err), int'(mon_e.er));
      cmp("err_cnt", int'(err_cnt), mon_e.cnt);
    end
  end

  // Stimulus: a clean timing generator with optional perturbations.
  localparam int P_NONE = 0, P_HDELAY = 1, P_VSHORT = 2, P_NOISE = 3, P_TOGGLE = 4;
  int gh = HSS, gv = 3, pert = P_NONE, pert_line = 0;
  bit gen_prev_hs = 1'b0, tog = 1'b1;

  task automatic drive(input bit r);
    bit hs_g, vs_g, hs, vs;
    @(negedge clk);
    hs_g = (gh >= HSS && gh < HSE);
    vs_g = (gv >= VSS && gv < VSE);
    hs = hs_g; vs = vs_g;
    case (pert)
      P_HDELAY: if (gv == pert_line) hs = gen_prev_hs;
      P_VSHORT: if (gv == VSE - 1) vs = 1'b0;
      P_NOISE: begin
        if ($urandom_range(63) == 0) hs = ~hs;
        if ($urandom_range(63) == 0) vs = ~vs;
      end
      P_TOGGLE: begin hs = tog; tog = ~tog; vs = 1'b0; end
      default: ;
    endcase
    gen_prev_hs = hs_g;
    rst_n = r; hsync_in = hs; vsync_in = vs;
    model_step(r, hs, vs);
    if (gh == HT - 1) begin gh = 0; gv = (gv == VT - 1) ? 0 : gv + 1; end
    else gh++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b1);
  endtask

  task automatic expect_locked(input string nm);
    vectors++;
    cmp(nm, int'(locked), 1);
  endtask

  initial begin
    // Reset while hsync is high, then a clean stream from mid-frame.
    for (int i = 0; i < 3; i++) drive(1'b0);
    run(5 * FRAME + $urandom_range(HT));
    expect_locked("lock_clean");

    pert = P_HDELAY; pert_line = 2 + $urandom_range(4);
    run(FRAME);
    pert = P_NONE;
    run(5 * FRAME);
    expect_locked("lock_after_hdelay");

    pert = P_VSHORT;
    run(FRAME);
    pert = P_NONE;
    run(5 * FRAME);
    expect_locked("lock_after_vshort");

    pert = P_NOISE;
    run(2000);
    pert = P_NONE;
    run(5 * FRAME);
    expect_locked("lock_after_noise");

    drive(1'b0);
    run(5 * FRAME + $urandom_range(2 * HT));
    expect_locked("lock_after_reset");

    pert = P_TOGGLE;
    run(600);
    pert = P_NONE;
    run(2 * FRAME);
    vectors++;
    cmp("err_cnt_saturated", int'(err_cnt), int'(EMAX));

    @(posedge clk);
    #2;
    vectors++;
    cmp("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
